// File: rtl/sample_pack_fifo_if.sv
// Bundle between the SPI result capture/host pipe side and the sample packer FIFO.
// The master drives capture and read controls; the slave returns data and status.
interface sample_pack_fifo_if #(
    parameter int ADDR_W = 10
);
    logic              enable;
    logic              flush;
    logic              clear_flags;
    logic              in_valid;
    logic [15:0]       in_data;
    logic              in_frame_start;
    logic              rd;
    logic [31:0]       out_data;
    logic              out_valid;
    logic [ADDR_W:0]   word_count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;
    logic [15:0]       drop_count;

    modport master (
        output enable, flush, clear_flags, in_valid, in_data, in_frame_start, rd,
        input  out_data, out_valid, word_count, empty, full, overflow, underflow, drop_count
    );

    modport slave (
        input  enable, flush, clear_flags, in_valid, in_data, in_frame_start, rd,
        output out_data, out_valid, word_count, empty, full, overflow, underflow, drop_count
    );
endinterface

// File: rtl/sample_pack_fifo.sv
// Packs pairs of 16-bit SPI result words into 32-bit words and buffers them in a
// block-RAM FIFO drained by the host pipe read strobe, with sticky error status.
module sample_pack_fifo #(
    parameter int          ADDR_W   = 10,
    parameter logic [15:0] PAD_WORD = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    sample_pack_fifo_if.slave bus
);
    localparam int               DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0]  DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

    localparam logic [0:0] LOW_EMPTY = 1'b0;
    localparam logic [0:0] LOW_HELD  = 1'b1;

    logic [0:0]        pack_state_reg, pack_state_next;
    logic [15:0]       held_reg, held_next;
    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W:0]   count_reg, count_next;
    logic              overflow_reg, overflow_next;
    logic              underflow_reg, underflow_next;
    logic [15:0]       drop_count_reg, drop_count_next;
    logic [31:0]       out_data_reg;
    logic              out_valid_reg;

    logic [31:0]       mem [DEPTH];

    logic              accept;
    logic              rd_req;
    logic              rd_accept;
    logic              rd_underflow;
    logic              fifo_empty;
    logic              fifo_full;
    logic              wr_req;
    logic              wr_accept;
    logic              wr_drop;
    logic [31:0]       wr_word;

    // flush takes priority over both capture and read in the same cycle
    always_comb begin
        accept       = bus.in_valid & bus.enable & ~bus.flush;
        rd_req       = bus.rd & ~bus.flush;
        fifo_empty   = (count_reg == '0);
        fifo_full    = (count_reg == DEPTH_CNT);
        rd_accept    = rd_req & ~fifo_empty;
        rd_underflow = rd_req & fifo_empty;
        wr_req       = accept & (pack_state_reg == LOW_HELD);
        wr_word      = bus.in_frame_start ? {PAD_WORD, held_reg} : {bus.in_data, held_reg};
        // a pop in the same cycle frees the slot the new word lands in
        wr_accept    = wr_req & (~fifo_full | rd_accept);
        wr_drop      = wr_req & ~wr_accept;
    end

    // A frame start while a half is held closes the old pair with padding and
    // keeps the new word as the next low half.
    always_comb begin
        pack_state_next = pack_state_reg;
        held_next       = held_reg;
        if (bus.flush) begin
            pack_state_next = LOW_EMPTY;
            held_next       = '0;
        end else if (accept) begin
            case (pack_state_reg)
                LOW_EMPTY: begin
                    held_next       = bus.in_data;
                    pack_state_next = LOW_HELD;
                end
                LOW_HELD: begin
                    if (bus.in_frame_start) begin
                        held_next       = bus.in_data;
                        pack_state_next = LOW_HELD;
                    end else begin
                        pack_state_next = LOW_EMPTY;
                    end
                end
                default: begin
                    pack_state_next = LOW_EMPTY;
                end
            endcase
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (bus.flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            case ({wr_accept, rd_accept})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    // Clearing and a fresh error in the same cycle leave the fresh error recorded.
    always_comb begin
        overflow_next   = bus.clear_flags ? 1'b0 : overflow_reg;
        underflow_next  = bus.clear_flags ? 1'b0 : underflow_reg;
        drop_count_next = bus.clear_flags ? 16'h0000 : drop_count_reg;
        if (wr_drop) begin
            overflow_next = 1'b1;
            if (drop_count_next != 16'hFFFF) begin
                drop_count_next = drop_count_next + 16'h0001;
            end
        end
        if (rd_underflow) begin
            underflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pack_state_reg <= LOW_EMPTY;
            held_reg       <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
            drop_count_reg <= '0;
            out_valid_reg  <= 1'b0;
        end else begin
            pack_state_reg <= pack_state_next;
            held_reg       <= held_next;
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            overflow_reg   <= overflow_next;
            underflow_reg  <= underflow_next;
            drop_count_reg <= drop_count_next;
            out_valid_reg  <= rd_accept;
        end
    end

    // Storage kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_accept && !reset) begin
            mem[wr_ptr_reg] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_reg <= '0;
        end else if (rd_accept) begin
            out_data_reg <= mem[rd_ptr_reg];
        end
    end

    assign bus.out_data   = out_data_reg;
    assign bus.out_valid  = out_valid_reg;
    assign bus.word_count = count_reg;
    assign bus.empty      = fifo_empty;
    assign bus.full       = fifo_full;
    assign bus.overflow   = overflow_reg;
    assign bus.underflow  = underflow_reg;
    assign bus.drop_count = drop_count_reg;
endmodule

// File: tb/tb_sample_pack_fifo.sv
// Directed scoreboard bench for sample_pack_fifo: expected packed words are queued at
// stimulus time and a negedge monitor checks every word the FIFO presents.
module tb_sample_pack_fifo;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset;

    sample_pack_fifo_if #(.ADDR_W(ADDR_W)) bus ();

    sample_pack_fifo #(
        .ADDR_W   (ADDR_W),
        .PAD_WORD (16'h0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    logic [31:0] exp_q [$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Monitor: every presented word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("FAIL out_data: got %h, expected no word", bus.out_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("out_data", bus.out_data, e);
                if (n_compared % 256 == 0 || exp_q.size() < 4)
                    $display("pop word %h (expected %h)", bus.out_data, e);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected run to finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic half(input logic [15:0] d, input logic fs, input logic r);
        bus.in_valid       = 1'b1;
        bus.in_data        = d;
        bus.in_frame_start = fs;
        bus.rd             = r;
        step();
        bus.in_valid       = 1'b0;
        bus.in_frame_start = 1'b0;
        bus.rd             = 1'b0;
    endtask

    task automatic read_n(input int n);
        bus.rd = 1'b1;
        repeat (n) step();
        bus.rd = 1'b0;
        step();
        step();
    endtask

    initial begin
        int avail;
        logic [15:0] lo;
        logic [15:0] hi;

        reset              = 1'b1;
        bus.enable         = 1'b0;
        bus.flush          = 1'b0;
        bus.clear_flags    = 1'b0;
        bus.in_valid       = 1'b0;
        bus.in_data        = 16'h0000;
        bus.in_frame_start = 1'b0;
        bus.rd             = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();

        check("rst out_data",   bus.out_data, 32'h0);
        check("rst out_valid",  32'(bus.out_valid), 32'h0);
        check("rst word_count", 32'(bus.word_count), 32'h0);
        check("rst empty",      32'(bus.empty), 32'h1);
        check("rst full",       32'(bus.full), 32'h0);
        check("rst overflow",   32'(bus.overflow), 32'h0);
        check("rst underflow",  32'(bus.underflow), 32'h0);
        check("rst drop_count", 32'(bus.drop_count), 32'h0);

        // enable low: in_valid ignored
        half(16'hDEAD, 1'b0, 1'b0);
        half(16'hBEEF, 1'b0, 1'b0);
        check("disabled word_count", 32'(bus.word_count), 32'h0);
        bus.enable = 1'b1;

        // 1: basic pair and read latency
        $display("txn: pair 1111/2222");
        half(16'h1111, 1'b0, 1'b0);
        exp_q.push_back(32'h2222_1111);
        half(16'h2222, 1'b0, 1'b0);
        check("t1 word_count", 32'(bus.word_count), 32'h1);
        bus.rd = 1'b1;
        step();
        bus.rd = 1'b0;
        check("t1 out_valid", 32'(bus.out_valid), 32'h1);
        check("t1 out_data",  bus.out_data, 32'h2222_1111);
        step();
        check("t1 empty", 32'(bus.empty), 32'h1);

        // 2: frame restart pads the held half
        $display("txn: frame restart AAAA/BBBB/CCCC");
        half(16'hAAAA, 1'b0, 1'b0);
        exp_q.push_back(32'h0000_AAAA);
        half(16'hBBBB, 1'b1, 1'b0);
        check("t2 word_count a", 32'(bus.word_count), 32'h1);
        exp_q.push_back(32'hCCCC_BBBB);
        half(16'hCCCC, 1'b0, 1'b0);
        check("t2 word_count b", 32'(bus.word_count), 32'h2);
        read_n(2);

        // 3: fill, overflow, write-while-full with read
        $display("txn: fill %0d words", DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            lo = i[15:0];
            hi = 16'h8000 | i[15:0];
            exp_q.push_back({hi, lo});
            half(lo, 1'b0, 1'b0);
            half(hi, 1'b0, 1'b0);
        end
        check("t3 full",       32'(bus.full), 32'h1);
        check("t3 word_count", 32'(bus.word_count), 32'd1024);
        half(16'hDEAD, 1'b0, 1'b0);
        half(16'hBEEF, 1'b0, 1'b0);
        check("t3 overflow",   32'(bus.overflow), 32'h1);
        check("t3 drop_count", 32'(bus.drop_count), 32'h1);
        check("t3 wc after drop", 32'(bus.word_count), 32'd1024);
        half(16'h0F0F, 1'b0, 1'b0);
        exp_q.push_back(32'hF0F0_0F0F);
        half(16'hF0F0, 1'b0, 1'b1);
        check("t3 rd+wr word_count", 32'(bus.word_count), 32'd1024);
        check("t3 rd+wr drop_count", 32'(bus.drop_count), 32'h1);
        read_n(DEPTH);
        check("t3 drained empty", 32'(bus.empty), 32'h1);

        // 4: underflow and clear_flags
        $display("txn: read while empty");
        bus.rd = 1'b1;
        step();
        bus.rd = 1'b0;
        check("t4 underflow", 32'(bus.underflow), 32'h1);
        check("t4 out_valid", 32'(bus.out_valid), 32'h0);
        bus.clear_flags = 1'b1;
        step();
        bus.clear_flags = 1'b0;
        check("t4 clr underflow",  32'(bus.underflow), 32'h0);
        check("t4 clr overflow",   32'(bus.overflow), 32'h0);
        check("t4 clr drop_count", 32'(bus.drop_count), 32'h0);

        // 5: flush with pending half, rd and in_valid asserted
        $display("txn: flush");
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({16'h4000 + i[15:0], 16'h3000 + i[15:0]});
            half(16'h3000 + i[15:0], 1'b0, 1'b0);
            half(16'h4000 + i[15:0], 1'b0, 1'b0);
        end
        check("t5 word_count", 32'(bus.word_count), 32'd5);
        half(16'h7777, 1'b0, 1'b0);
        bus.flush    = 1'b1;
        bus.rd       = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h9999;
        step();
        bus.flush    = 1'b0;
        bus.rd       = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        check("t5 flush word_count", 32'(bus.word_count), 32'h0);
        check("t5 flush empty",      32'(bus.empty), 32'h1);
        check("t5 flush out_valid",  32'(bus.out_valid), 32'h0);
        check("t5 flush underflow",  32'(bus.underflow), 32'h0);
        exp_q.push_back(32'h5678_1234);
        half(16'h1234, 1'b0, 1'b0);
        half(16'h5678, 1'b0, 1'b0);
        check("t5 post word_count", 32'(bus.word_count), 32'h1);
        read_n(1);

        // 6: continuous streaming with wraparound
        $display("txn: stream 3000 pairs");
        avail = 0;
        for (int p = 0; p < 3000; p++) begin
            lo = p[15:0] ^ 16'h5A5A;
            hi = p[15:0] + 16'h1000;
            half(lo, 1'b0, avail > 0);
            if (avail > 0) avail--;
            exp_q.push_back({hi, lo});
            half(hi, 1'b0, avail > 0);
            if (avail > 0) avail--;
            avail++;
        end
        read_n(avail);
        check("t6 empty",      32'(bus.empty), 32'h1);
        check("t6 underflow",  32'(bus.underflow), 32'h0);
        check("t6 drop_count", 32'(bus.drop_count), 32'h0);

        // reset mid-frame discards stored data and the pending half
        $display("txn: reset mid-frame");
        half(16'h3333, 1'b0, 1'b0);
        half(16'h4444, 1'b0, 1'b0);
        half(16'h4444, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t7 word_count", 32'(bus.word_count), 32'h0);
        exp_q.push_back(32'h6666_5555);
        half(16'h5555, 1'b0, 1'b0);
        half(16'h6666, 1'b0, 1'b0);
        read_n(1);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) step();
        check("scoreboard drained", exp_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
